// File: rtl/pf_iod_lvds_tx_pkg.sv
// rtl/pf_iod_lvds_tx_pkg.sv - shared types and constants for the LVDS TX framer
package pf_iod_lvds_tx_pkg;

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DATA  = 2'd2
  } tx_state_e;

  localparam logic [7:0] DEF_TRAIN_PATTERN = 8'hB2;
  localparam logic [7:0] DEF_IDLE_PATTERN  = 8'h00;

  // x^7 + x^6 + 1: feedback from bits 6 and 5
  localparam logic [6:0] PRBS7_TAPS = 7'h60;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  // One PRBS7 shift; the new bit enters at bit 0 and is the output bit
  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/pf_iod_lvds_tx_fifo.sv
// rtl/pf_iod_lvds_tx_fifo.sv - synchronous FIFO buffering user words ahead of the framer
module pf_iod_lvds_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Next-state for storage, pointers (wrapping at DEPTH) and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Pointer and count registers; reset empties the buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries behind a valid count are read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pf_iod_lvds_tx_framer.sv
// rtl/pf_iod_lvds_tx_framer.sv - LVDS TX framer: training, idle and buffered data onto the serializer word
// Optional PRBS7 test source enabled by defining PF_IOD_LVDS_TX_PRBS_EN.
module pf_iod_lvds_tx_framer
  import pf_iod_lvds_tx_pkg::*;
#(
  parameter int                LANES         = 4,
  parameter int                DATA_W        = 8,
  parameter int                TRAIN_CYCLES  = 64,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter logic [DATA_W-1:0] IDLE_PATTERN  = DEF_IDLE_PATTERN,
  parameter int                FIFO_DEPTH    = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [LANES*DATA_W-1:0] TX_DATA,
  input  logic                    TX_VALID,
  output logic                    TX_READY,
  input  logic                    RETRAIN,
`ifdef PF_IOD_LVDS_TX_PRBS_EN
  input  logic                    PRBS_MODE,
`endif
  output logic [LANES*DATA_W-1:0] TXD,
  output logic                    TRAINING,
  output logic                    LINK_UP,
  output logic                    UNDERRUN
);

  localparam int W  = LANES * DATA_W;
  localparam int CW = $clog2(TRAIN_CYCLES + 1);

  tx_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   txd_q, txd_d;
  logic           training_q, training_d;
  logic           link_up_q, link_up_d;
  logic           underrun_q, underrun_d;
  logic           rst_done_q;

  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [W-1:0]   fifo_head;

  assign TX_READY  = rst_done_q && !fifo_full;
  assign fifo_push = TX_VALID && TX_READY;
  assign TXD       = txd_q;
  assign TRAINING  = training_q;
  assign LINK_UP   = link_up_q;
  assign UNDERRUN  = underrun_q;

  pf_iod_lvds_tx_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (fifo_push),
    .push_data (TX_DATA),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef PF_IOD_LVDS_TX_PRBS_EN
  logic [6:0]        prbs_q, prbs_d, prbs_next;
  logic [DATA_W-1:0] prbs_word;

  // Advance PRBS7 by DATA_W bits; the earliest bit lands in the word MSB
  always_comb begin
    prbs_next = prbs_q;
    prbs_word = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      prbs_next    = prbs7_step(prbs_next);
      prbs_word[i] = prbs_next[0];
    end
  end
`endif

  // Framer next-state: RETRAIN first, then TRAIN / IDLE / DATA behaviour
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    txd_d      = {LANES{IDLE_PATTERN}};
    training_d = 1'b0;
    link_up_d  = link_up_q;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
`ifdef PF_IOD_LVDS_TX_PRBS_EN
    prbs_d     = prbs_q;
`endif
    if (RETRAIN) begin
      // Leaving IDLE/DATA emits one idle word; inside TRAIN the pattern stays continuous
      state_d = ST_TRAIN;
      cnt_d   = '0;
      if (state_q == ST_TRAIN) begin
        txd_d      = {LANES{TRAIN_PATTERN}};
        training_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_TRAIN: begin
          txd_d      = {LANES{TRAIN_PATTERN}};
          training_d = 1'b1;
          if (cnt_q == CW'(TRAIN_CYCLES - 1)) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            link_up_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_IDLE: begin
`ifdef PF_IOD_LVDS_TX_PRBS_EN
          if (PRBS_MODE) begin
            txd_d  = {LANES{prbs_word}};
            prbs_d = prbs_next;
          end else
`endif
          if (!fifo_empty) begin
            state_d  = ST_DATA;
            fifo_pop = 1'b1;
            txd_d    = fifo_head;
          end
        end
        ST_DATA: begin
`ifdef PF_IOD_LVDS_TX_PRBS_EN
          if (PRBS_MODE) begin
            txd_d  = {LANES{prbs_word}};
            prbs_d = prbs_next;
          end else
`endif
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            txd_d    = fifo_head;
          end else begin
            state_d    = ST_IDLE;
            underrun_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_TRAIN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM and registered outputs; reset discards any burst in progress
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_TRAIN;
      cnt_q      <= '0;
      txd_q      <= {LANES{IDLE_PATTERN}};
      training_q <= 1'b0;
      link_up_q  <= 1'b0;
      underrun_q <= 1'b0;
      rst_done_q <= 1'b0;
`ifdef PF_IOD_LVDS_TX_PRBS_EN
      prbs_q     <= PRBS7_SEED;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txd_q      <= txd_d;
      training_q <= training_d;
      link_up_q  <= link_up_d;
      underrun_q <= underrun_d;
      rst_done_q <= 1'b1;
`ifdef PF_IOD_LVDS_TX_PRBS_EN
      prbs_q     <= prbs_d;
`endif
    end
  end

endmodule

// File: tb/tb_pf_iod_lvds_tx_framer.sv
// tb/tb_pf_iod_lvds_tx_framer.sv - scoreboard bench for the LVDS TX framer
module tb_pf_iod_lvds_tx_framer;

  localparam logic [31:0] TRAIN_WORD = 32'hB2B2B2B2;
  localparam logic [31:0] IDLE_WORD  = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        retrain = 1'b0;
  logic        prbs_mode = 1'b0;
  logic        prbs_mode_d = 1'b0;
  logic [31:0] txd;
  logic        training;
  logic        link_up;
  logic        underrun;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_data[$];
  int          exp_train[$];

  always #5 clk = ~clk;

  pf_iod_lvds_tx_framer dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .TX_DATA  (tx_data),
    .TX_VALID (tx_valid),
    .TX_READY (tx_ready),
    .RETRAIN  (retrain),
`ifdef PF_IOD_LVDS_TX_PRBS_EN
    .PRBS_MODE(prbs_mode),
`endif
    .TXD      (txd),
    .TRAINING (training),
    .LINK_UP  (link_up),
    .UNDERRUN (underrun)
  );

  always @(posedge clk) prbs_mode_d <= prbs_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_txd(input logic [31:0] w, input string name);
    bit found = 0;
    for (int i = 0; i < 200; i++) begin
      if (txd === w) begin
        found = 1;
        break;
      end
      tick();
    end
    check(name, txd, w);
  endtask

  task automatic pulse_retrain();
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
  endtask

  // Monitor: training run lengths and data words are popped from the scoreboard queues
  initial begin
    int run_len = 0;
    int exp_len;
    forever begin
      @(negedge clk);
      if (training) begin
        check("train_word", txd, TRAIN_WORD);
        run_len++;
      end else begin
        if (run_len != 0) begin
          if (exp_train.size() == 0) begin
            total++;
            bad++;
            $display("FAIL train_run: unexpected burst of %0d cycles", run_len);
          end else begin
            exp_len = exp_train.pop_front();
            check("train_run_len", run_len, exp_len);
          end
          run_len = 0;
        end
        if (txd !== IDLE_WORD && !prbs_mode && !prbs_mode_d) begin
          if (exp_data.size() == 0) begin
            total++;
            bad++;
            $display("FAIL data_word: unexpected %h", txd);
          end else begin
            check("data_word", txd, exp_data.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[5];
    int n;

    // Reset state
    tick();
    tick();
    check("rst_txd", txd, IDLE_WORD);
    check("rst_training", training, 1'b0);
    check("rst_link_up", link_up, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_underrun", underrun, 1'b0);

    // Initial training burst, no traffic
    exp_train.push_back(64);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i == 0) begin
        check("train0_training", training, 1'b1);
        check("train0_link_up", link_up, 1'b0);
      end
      if (i == 62) check("train62_link_up", link_up, 1'b0);
      if (i == 63) begin
        check("train63_txd", txd, TRAIN_WORD);
        check("train63_link_up", link_up, 1'b1);
      end
    end
    tick();
    check("post_train_txd", txd, IDLE_WORD);
    check("post_train_training", training, 1'b0);
    check("post_train_link_up", link_up, 1'b1);

    // Single word: visible two cycles after presentation, then underrun
    check("single_ready", tx_ready, 1'b1);
    tx_data = 32'h11223344;
    tx_valid = 1'b1;
    exp_data.push_back(32'h11223344);
    tick();
    tx_valid = 1'b0;
    check("single_lat1", txd, IDLE_WORD);
    tick();
    check("single_lat2", txd, 32'h11223344);
    tick();
    check("single_idle", txd, IDLE_WORD);
    check("single_underrun", underrun, 1'b1);
    tick();
    check("single_underrun_end", underrun, 1'b0);

    // Fill the FIFO during training; fifth word refused
    w[0] = 32'hA1A2A3A4; w[1] = 32'hB1B2B3B4; w[2] = 32'hC1C2C3C4;
    w[3] = 32'hD1D2D3D4; w[4] = 32'hE1E2E3E4;
    exp_train.push_back(64);
    pulse_retrain();
    tx_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tx_data = w[k];
      check("fill_ready", tx_ready, (k < 4) ? 1'b1 : 1'b0);
      if (k < 4) exp_data.push_back(w[k]);
      tick();
    end
    tx_valid = 1'b0;
    wait_txd(w[0], "fill_w0");
    tick();
    check("fill_w1", txd, w[1]);
    tick();
    check("fill_w2", txd, w[2]);
    tick();
    check("fill_w3", txd, w[3]);
    tick();
    check("fill_idle", txd, IDLE_WORD);
    check("fill_underrun", underrun, 1'b1);

    // RETRAIN in DATA with 3 queued, restarted at training cycle 10
    w[0] = 32'h10203040; w[1] = 32'h50607080; w[2] = 32'h90A0B0C0; w[3] = 32'hD0E0F001;
    exp_train.push_back(64);
    pulse_retrain();
    tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_data = w[k];
      exp_data.push_back(w[k]);
      tick();
    end
    tx_valid = 1'b0;
    wait_txd(w[0], "rt_b0");
    exp_train.push_back(75);
    pulse_retrain();
    check("rt_edge_txd", txd, IDLE_WORD);
    check("rt_edge_training", training, 1'b0);
    repeat (10) tick();
    check("rt_mid_training", training, 1'b1);
    pulse_retrain();
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!training) break;
      n++;
    end
    check("rt_restart_len", n, 64);
    check("rt_link_up", link_up, 1'b1);
    wait_txd(w[1], "rt_b1");
    wait_txd(w[3], "rt_b3");
    tick();
    check("rt_underrun", underrun, 1'b1);

    // Reset mid-DATA with two words queued: they must never appear
    w[0] = 32'h0F0E0D0C; w[1] = 32'h1F1E1D1C; w[2] = 32'h2F2E2D2C;
    exp_train.push_back(64);
    pulse_retrain();
    tx_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_data = w[k];
      if (k == 0) exp_data.push_back(w[k]);
      tick();
    end
    tx_valid = 1'b0;
    wait_txd(w[0], "rst_c0");
    exp_train.push_back(64);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_txd", txd, IDLE_WORD);
    check("mid_rst_link_up", link_up, 1'b0);
    check("mid_rst_tx_ready", tx_ready, 1'b0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (link_up) break;
      n++;
    end
    check("mid_rst_relink", link_up, 1'b1);
    repeat (8) tick();
    check("mid_rst_idle", txd, IDLE_WORD);

`ifdef PF_IOD_LVDS_TX_PRBS_EN
    // PRBS source: first words from seed 7F are 02 and 0C; period 127 words
    prbs_mode = 1'b1;
    tx_data = 32'hA5A5A5A5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("prbs_w0", txd, 32'h02020202);
    check("prbs_ready", tx_ready, 1'b1);
    tick();
    check("prbs_w1", txd, 32'h0C0C0C0C);
    repeat (125) tick();
    tick();
    check("prbs_period", txd, 32'h02020202);
    exp_data.push_back(32'hA5A5A5A5);
    prbs_mode = 1'b0;
    wait_txd(32'hA5A5A5A5, "prbs_held_word");
`endif

    repeat (6) tick();
    check("end_data_queue", exp_data.size(), 0);
    check("end_train_queue", exp_train.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pf_iod_lvds_tx_framer.md
Name: pf_iod_lvds_tx_framer

Overview:
- Fabric-side transmit framer for the PolarFire LVDS TX IOD path.
- Runs in the divided (CLK_DIV) domain and feeds the TX serializer's parallel inputs, LANES lanes x DATA_W bits per cycle.
- After reset, and on request, it sends a fixed training word so the far-end receiver can bit-slip and word-align. Otherwise it sends buffered user words, or an idle word when there are none.

Parameters:
- LANES, 4, number of LVDS data lanes.
- DATA_W, 8, bits per lane per CLK cycle (serializer ratio).
- TRAIN_CYCLES, 64, CLK cycles of training per training burst; must be >= 1.
- TRAIN_PATTERN, 8'hB2, per-lane training word (DATA_W bits), replicated on all lanes.
- IDLE_PATTERN, 8'h00, per-lane word sent when no data is queued.
- FIFO_DEPTH, 4, input buffer depth; power of two, >= 2.

Ports:
- CLK  in  1  divided TX clock (CLK_DIV domain); all logic on its rising edge.
- RST_N  in  1  synchronous active-low reset.
- TX_DATA  in  LANES*DATA_W  user word; lane n occupies bits [n*DATA_W +: DATA_W].
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  buffer can accept a word.
- RETRAIN  in  1  single-cycle request for a new training burst.
- TXD  out  LANES*DATA_W  registered parallel word to the IOD serializers.
- TRAINING  out  1  high while TXD carries TRAIN_PATTERN.
- LINK_UP  out  1  high once the first training burst is complete; cleared only by reset.
- UNDERRUN  out  1  one-cycle pulse when DATA state falls back to IDLE.

Behaviour:
- Reset (RST_N=0 at a clock edge):
  - FIFO empty; state TRAIN; training counter = 0.
  - TXD = IDLE_PATTERN replicated; TRAINING=0; LINK_UP=0; TX_READY=0; UNDERRUN=0.
  - Reset asserted mid-operation discards FIFO contents and any burst in progress.
- TX_READY = !full && RST_N-released for at least one cycle. A transfer occurs on a cycle with TX_VALID && TX_READY. Words are accepted during TRAIN and are held until DATA.
- FSM states:
  - TRAIN:
    - TXD <= TRAIN_PATTERN on all lanes; TRAINING <= 1.
    - Counter increments each cycle. When it reaches TRAIN_CYCLES-1, the next state is IDLE and LINK_UP <= 1.
    - Exactly TRAIN_CYCLES consecutive training words appear on TXD.
  - IDLE:
    - TXD <= IDLE_PATTERN.
    - If the FIFO is non-empty, go to DATA; the head word is popped in that same cycle and appears on TXD on the next edge.
  - DATA:
    - While the FIFO is non-empty, pop one word per cycle; TXD <= popped word.
    - If the FIFO is empty, go to IDLE: TXD <= IDLE_PATTERN and UNDERRUN pulses for 1 cycle.
- RETRAIN has priority over everything:
  - Sampled in any state. Next state is TRAIN with the counter cleared.
  - A RETRAIN during TRAIN restarts the count.
  - FIFO contents are kept, no pops occur during TRAIN, and LINK_UP is unchanged.
- Latency: a word written into an empty FIFO while in IDLE reaches TXD 2 cycles after the accepting edge (push, then pop and register).
- Simultaneous push and pop when full: not permitted (TX_READY=0). When not full, both take effect and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. The occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.
- TXD is registered directly with no combinational path from TX_DATA. Lane ordering is preserved.

Optional Feature:
- Macro PF_IOD_LVDS_TX_PRBS_EN.
- Defined:
  - Adds input PRBS_MODE (1 bit) and a PRBS7 generator (x^7+x^6+1), seed 7'h7F at reset. It produces DATA_W bits per cycle, MSB first, and the same sequence is sent on all lanes.
  - When PRBS_MODE=1 in IDLE or DATA, TXD carries the PRBS word, FIFO pops stop, and TX_READY still reflects FIFO space.
  - TRAIN overrides PRBS.
- Undefined: no PRBS_MODE port and no generator logic.

Decomposition:
- Package pf_iod_lvds_tx_pkg holds:
  - state enum (TRAIN, IDLE, DATA);
  - default TRAIN_PATTERN and IDLE_PATTERN constants;
  - the PRBS7 tap constant.
- One sub-module: pf_iod_lvds_tx_fifo, a synchronous FIFO with width LANES*DATA_W and depth FIFO_DEPTH. It exposes push, pop, full, empty and head data.

Test Plan:
- Reset release, no traffic:
  - TXD = 32'hB2B2B2B2 with TRAINING=1 for exactly 64 cycles.
  - Then 32'h00000000; LINK_UP rises on the first IDLE cycle.
- After LINK_UP, push 32'h11223344 on one cycle:
  - TXD = 32'h11223344 two cycles later, then IDLE_PATTERN.
  - UNDERRUN pulses once.
- During TRAIN, push 4 words with TX_VALID held high:
  - TX_READY drops after the 4th word and a 5th word is not accepted.
  - After training, the 4 words appear on consecutive cycles in order.
- In DATA with 3 words queued, pulse RETRAIN:
  - 64 training cycles follow (restarted if RETRAIN pulses again at cycle 10).
  - The 3 words are then sent intact; LINK_UP stays 1.
- Deassert RST_N for 1 cycle with 2 words queued mid-DATA:
  - TXD = IDLE_PATTERN and LINK_UP=0 at the next edge.
  - Training restarts and the queued words are never sent.
- With PF_IOD_LVDS_TX_PRBS_EN defined and PRBS_MODE=1 after training:
  - The first TXD lane word equals the first 8 bits of PRBS7 from seed 7'h7F.
  - The sequence repeats every 127 bits; no FIFO pops occur.
